// File: rtl/video_pkg.sv
// Shared video definitions: RGB888 byte positions, RGB565 field layout and
// the packer state encoding. Used by the RGB565 packer and unpacker.
package video_pkg;

    // RGB888 channel byte offsets inside a 32-bit video beat ([7:0] unused)
    localparam int RGB888_R_LSB = 24;
    localparam int RGB888_G_LSB = 16;
    localparam int RGB888_B_LSB = 8;
    localparam int RGB888_CH_W  = 8;

    // RGB565 field offsets and widths inside a 16-bit pixel
    localparam int RGB565_R_LSB = 0;
    localparam int RGB565_R_W   = 5;
    localparam int RGB565_G_LSB = 5;
    localparam int RGB565_G_W   = 6;
    localparam int RGB565_B_LSB = 11;
    localparam int RGB565_B_W   = 5;
    localparam int RGB565_W     = 16;

    // Packer states: hold empty, pix0 held, misaligned-SOF flush, odd-line tail
    typedef enum logic [1:0] {
        EVEN     = 2'd0,
        ODD      = 2'd1,
        FLUSH    = 2'd2,
        ODD_LAST = 2'd3
    } pack_state_e;

    // One converted pixel with its sideband, as carried by the optional stage
    typedef struct packed {
        logic [RGB565_W-1:0] pix;
        logic                user;
        logic                last;
    } pix_beat_t;

    // Place 5/6/5 channel values into their RGB565 fields
    function automatic logic [RGB565_W-1:0] pack_565(
        input logic [RGB565_R_W-1:0] r,
        input logic [RGB565_G_W-1:0] g,
        input logic [RGB565_B_W-1:0] b
    );
        logic [RGB565_W-1:0] p;
        p = 16'h0000;
        p[RGB565_R_LSB +: RGB565_R_W] = r;
        p[RGB565_G_LSB +: RGB565_G_W] = g;
        p[RGB565_B_LSB +: RGB565_B_W] = b;
        return p;
    endfunction

endpackage

// File: rtl/rgb888_to_565.sv
// Combinational RGB888 -> RGB565 pixel converter.
// Build option VIDEO_PACKER_ROUND_EN: round-to-nearest with saturation
// instead of plain truncation.
module rgb888_to_565 import video_pkg::*; (
    input  logic [31:0]         rgb,
    output logic [RGB565_W-1:0] pix
);

    logic [RGB888_CH_W-1:0] r8_s;
    logic [RGB888_CH_W-1:0] g8_s;
    logic [RGB888_CH_W-1:0] b8_s;
    logic [RGB565_R_W-1:0]  r5_s;
    logic [RGB565_G_W-1:0]  g6_s;
    logic [RGB565_B_W-1:0]  b5_s;
    logic                   unused_s;

    assign r8_s = rgb[RGB888_R_LSB +: RGB888_CH_W];
    assign g8_s = rgb[RGB888_G_LSB +: RGB888_CH_W];
    assign b8_s = rgb[RGB888_B_LSB +: RGB888_CH_W];

`ifdef VIDEO_PACKER_ROUND_EN
    // 9-bit sums keep the carry; a set carry means the rounded value
    // overflowed the field and is clamped to full scale.
    logic [8:0] r_sum_s;
    logic [8:0] g_sum_s;
    logic [8:0] b_sum_s;

    assign r_sum_s = {1'b0, r8_s} + 9'd4;
    assign g_sum_s = {1'b0, g8_s} + 9'd2;
    assign b_sum_s = {1'b0, b8_s} + 9'd4;

    assign r5_s = r_sum_s[8] ? 5'h1F : r_sum_s[7:3];
    assign g6_s = g_sum_s[8] ? 6'h3F : g_sum_s[7:2];
    assign b5_s = b_sum_s[8] ? 5'h1F : b_sum_s[7:3];

    assign unused_s = ^{rgb[7:0], r_sum_s[2:0], g_sum_s[1:0], b_sum_s[2:0]};
`else
    assign r5_s = r8_s[7:3];
    assign g6_s = g8_s[7:2];
    assign b5_s = b8_s[7:3];

    assign unused_s = ^{rgb[7:0], r8_s[2:0], g8_s[1:0], b8_s[2:0]};
`endif

    assign pix = pack_565(r5_s, g6_s, b5_s);

endmodule

// File: rtl/video_packer_565.sv
// Packs two consecutive RGB888 video beats into one word of two RGB565
// pixels {pix1, pix0}, keeping frame start (tuser) and end of line (tlast).
// Odd lines are padded; a tuser arriving on the second pixel flushes the
// held pixel as a one-pixel word and raises sof_error.
// Build option VIDEO_PACKER_ROUND_EN: rounding converter plus one extra
// skid-buffered register stage in front of the packer.
module video_packer_565 import video_pkg::*; #(
    parameter bit PAD_DUPLICATE = 1'b0
) (
    input  logic        m_axis_vid_aclk,
    input  logic        m_axis_vid_reset,
    input  logic [31:0] m_axis_vid_tdata,
    input  logic        m_axis_vid_tvalid,
    output logic        m_axis_vid_tready,
    input  logic        m_axis_vid_tuser,
    input  logic        m_axis_vid_tlast,
    output logic [31:0] s_axis_vid_tdata,
    output logic        s_axis_vid_tvalid,
    input  logic        s_axis_vid_tready,
    output logic        s_axis_vid_tuser,
    output logic        s_axis_vid_tlast,
    output logic        sof_error
);

    logic [RGB565_W-1:0] conv_pix_s;
    logic                pk_valid_s;
    logic                pk_ready_s;
    logic [RGB565_W-1:0] pk_pix_s;
    logic                pk_user_s;
    logic                pk_last_s;

    rgb888_to_565 u_conv (
        .rgb (m_axis_vid_tdata),
        .pix (conv_pix_s)
    );

`ifdef VIDEO_PACKER_ROUND_EN
    pix_beat_t in_beat_s;
    pix_beat_t main_r;
    pix_beat_t skid_r;
    logic      main_valid_r;
    logic      skid_valid_r;
    logic      in_acc_s;
    logic      pk_acc_s;

    assign in_beat_s         = '{pix: conv_pix_s, user: m_axis_vid_tuser, last: m_axis_vid_tlast};
    assign m_axis_vid_tready = !skid_valid_r;
    assign in_acc_s          = m_axis_vid_tvalid && !skid_valid_r;
    assign pk_acc_s          = main_valid_r && pk_ready_s;

    assign pk_valid_s = main_valid_r;
    assign pk_pix_s   = main_r.pix;
    assign pk_user_s  = main_r.user;
    assign pk_last_s  = main_r.last;

    // Main register feeds the packer; skid catches the beat accepted while main stalls
    always_ff @(posedge m_axis_vid_aclk) begin
        if (m_axis_vid_reset) begin
            main_r       <= '0;
            skid_r       <= '0;
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (pk_acc_s || !main_valid_r) begin
            if (skid_valid_r) begin
                main_r       <= skid_r;
                main_valid_r <= 1'b1;
                skid_valid_r <= 1'b0;
            end else if (in_acc_s) begin
                main_r       <= in_beat_s;
                main_valid_r <= 1'b1;
            end else begin
                main_valid_r <= 1'b0;
            end
        end else if (in_acc_s) begin
            skid_r       <= in_beat_s;
            skid_valid_r <= 1'b1;
        end
    end
`else
    assign pk_valid_s        = m_axis_vid_tvalid;
    assign pk_pix_s          = conv_pix_s;
    assign pk_user_s         = m_axis_vid_tuser;
    assign pk_last_s         = m_axis_vid_tlast;
    assign m_axis_vid_tready = pk_ready_s;
`endif

    pack_state_e         state_r;
    pack_state_e         state_s;
    logic [RGB565_W-1:0] hold_pix_r;
    logic                hold_user_r;
    logic [31:0]         tdata_r;
    logic                tvalid_r;
    logic                tuser_r;
    logic                tlast_r;
    logic                sof_error_r;
    logic                can_load_s;
    logic                latch_s;
    logic                load_s;
    logic [31:0]         word_s;
    logic                user_s;
    logic                last_s;
    logic                sof_s;
    logic [RGB565_W-1:0] pad_s;

    assign can_load_s = !tvalid_r || s_axis_vid_tready;
    assign pad_s      = PAD_DUPLICATE ? hold_pix_r : 16'h0000;

    // Next state, input ready and output-word load decisions
    always_comb begin
        state_s    = state_r;
        pk_ready_s = 1'b0;
        latch_s    = 1'b0;
        load_s     = 1'b0;
        word_s     = 32'h0000_0000;
        user_s     = 1'b0;
        last_s     = 1'b0;
        sof_s      = 1'b0;
        case (state_r)
            EVEN: begin
                pk_ready_s = 1'b1;
                if (pk_valid_s) begin
                    latch_s = 1'b1;
                    state_s = pk_last_s ? ODD_LAST : ODD;
                end else begin
                    state_s = EVEN;
                end
            end
            ODD: begin
                pk_ready_s = can_load_s && !(pk_user_s && pk_valid_s);
                if (pk_valid_s && pk_user_s) begin
                    state_s = FLUSH;
                end else if (pk_valid_s && can_load_s) begin
                    load_s  = 1'b1;
                    word_s  = {pk_pix_s, hold_pix_r};
                    user_s  = hold_user_r;
                    last_s  = pk_last_s;
                    state_s = EVEN;
                end else begin
                    state_s = ODD;
                end
            end
            FLUSH: begin
                if (can_load_s) begin
                    load_s  = 1'b1;
                    word_s  = {pad_s, hold_pix_r};
                    user_s  = hold_user_r;
                    last_s  = 1'b1;
                    sof_s   = 1'b1;
                    state_s = EVEN;
                end else begin
                    state_s = FLUSH;
                end
            end
            ODD_LAST: begin
                if (can_load_s) begin
                    load_s  = 1'b1;
                    word_s  = {pad_s, hold_pix_r};
                    user_s  = hold_user_r;
                    last_s  = 1'b1;
                    state_s = EVEN;
                end else begin
                    state_s = ODD_LAST;
                end
            end
            default: begin
                state_s = EVEN;
            end
        endcase
    end

    // State register and held first pixel of the pair
    always_ff @(posedge m_axis_vid_aclk) begin
        if (m_axis_vid_reset) begin
            state_r     <= EVEN;
            hold_pix_r  <= 16'h0000;
            hold_user_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (latch_s) begin
                hold_pix_r  <= pk_pix_s;
                hold_user_r <= pk_user_s;
            end
        end
    end

    // Output word register: loads a new word or drains on downstream ready
    always_ff @(posedge m_axis_vid_aclk) begin
        if (m_axis_vid_reset) begin
            tdata_r     <= 32'h0000_0000;
            tvalid_r    <= 1'b0;
            tuser_r     <= 1'b0;
            tlast_r     <= 1'b0;
            sof_error_r <= 1'b0;
        end else begin
            if (load_s) begin
                tdata_r  <= word_s;
                tvalid_r <= 1'b1;
                tuser_r  <= user_s;
                tlast_r  <= last_s;
            end else if (s_axis_vid_tready) begin
                tvalid_r <= 1'b0;
            end
            sof_error_r <= sof_s;
        end
    end

    assign s_axis_vid_tdata  = tdata_r;
    assign s_axis_vid_tvalid = tvalid_r;
    assign s_axis_vid_tuser  = tuser_r;
    assign s_axis_vid_tlast  = tlast_r;
    assign sof_error         = sof_error_r;

endmodule

// File: tb/tb_video_packer_565.sv
// Self-checking bench for video_packer_565. Two instances share all inputs:
// dut0 pads odd lines with zero, dut1 duplicates the lower pixel.
module tb_video_packer_565;

`ifdef VIDEO_PACKER_ROUND_EN
    localparam bit ROUND   = 1'b1;
    localparam int EXP_LAT = 2;
`else
    localparam bit ROUND   = 1'b0;
    localparam int EXP_LAT = 1;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tuser;
    logic        m_tlast;
    logic        s_tready;

    logic        m_tready0, s_tvalid0, s_tuser0, s_tlast0, sof0;
    logic [31:0] s_tdata0;
    logic        m_tready1, s_tvalid1, s_tuser1, s_tlast1, sof1;
    logic [31:0] s_tdata1;

    video_packer_565 #(.PAD_DUPLICATE(1'b0)) dut0 (
        .m_axis_vid_aclk   (clk),
        .m_axis_vid_reset  (rst),
        .m_axis_vid_tdata  (m_tdata),
        .m_axis_vid_tvalid (m_tvalid),
        .m_axis_vid_tready (m_tready0),
        .m_axis_vid_tuser  (m_tuser),
        .m_axis_vid_tlast  (m_tlast),
        .s_axis_vid_tdata  (s_tdata0),
        .s_axis_vid_tvalid (s_tvalid0),
        .s_axis_vid_tready (s_tready),
        .s_axis_vid_tuser  (s_tuser0),
        .s_axis_vid_tlast  (s_tlast0),
        .sof_error         (sof0)
    );

    video_packer_565 #(.PAD_DUPLICATE(1'b1)) dut1 (
        .m_axis_vid_aclk   (clk),
        .m_axis_vid_reset  (rst),
        .m_axis_vid_tdata  (m_tdata),
        .m_axis_vid_tvalid (m_tvalid),
        .m_axis_vid_tready (m_tready1),
        .m_axis_vid_tuser  (m_tuser),
        .m_axis_vid_tlast  (m_tlast),
        .s_axis_vid_tdata  (s_tdata1),
        .s_axis_vid_tvalid (s_tvalid1),
        .s_axis_vid_tready (s_tready),
        .s_axis_vid_tuser  (s_tuser1),
        .s_axis_vid_tlast  (s_tlast1),
        .sof_error         (sof1)
    );

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic        user;
        logic        last;
    } word_t;

    typedef struct {
        logic [31:0] p0;
        logic [31:0] p1;
        logic [31:0] exp_t;
        logic [31:0] exp_r;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    word_t       exp_q[$];
    word_t       got_q[$];
    bit          pend_v = 1'b0;
    logic [15:0] pend_pix;
    logic        pend_user;
    int          exp_sof = 0;
    int          obs_sof = 0;
    logic [31:0] sof_data = 32'h0;
    bit          saw_ready_low = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference conversion straight from the channel arithmetic
    function automatic logic [15:0] conv(input logic [31:0] d);
        int r, g, b;
        r = int'(d[31:24]);
        g = int'(d[23:16]);
        b = int'(d[15:8]);
        if (ROUND) begin
            r = (r + 4) / 8;
            g = (g + 2) / 4;
            b = (b + 4) / 8;
            if (r > 31) r = 31;
            if (g > 63) g = 63;
            if (b > 31) b = 31;
        end else begin
            r = r / 8;
            g = g / 4;
            b = b / 8;
        end
        return 16'(b * 2048 + g * 32 + r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Line-level model: pairs pixels, pads odd lines, flushes on early SOF
    task automatic model_beat(input logic [31:0] d, input logic u, input logic l);
        logic [15:0] p;
        p = conv(d);
        if (pend_v && u) begin
            exp_q.push_back('{{16'h0000, pend_pix}, {pend_pix, pend_pix}, pend_user, 1'b1});
            exp_sof++;
            pend_v = 1'b0;
        end
        if (!pend_v) begin
            if (l) begin
                exp_q.push_back('{{16'h0000, p}, {p, p}, u, 1'b1});
            end else begin
                pend_v    = 1'b1;
                pend_pix  = p;
                pend_user = u;
            end
        end else begin
            exp_q.push_back('{{p, pend_pix}, {p, pend_pix}, pend_user, l});
            pend_v = 1'b0;
        end
    endtask

    // Monitor on the falling edge: handshakes, scoreboard, stall stability
    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_v     = 1'b0;
                prev_stall = 1'b0;
                exp_q.delete();
            end else begin
                check("dut1_ctrl", {27'd0, m_tready1, s_tvalid1, s_tuser1, s_tlast1, sof1},
                      {27'd0, m_tready0, s_tvalid0, s_tuser0, s_tlast0, sof0});
                if (prev_stall) begin
                    check1("stall_valid", s_tvalid0, 1'b1);
                    check("stall_data", s_tdata0, prev_data);
                end
                prev_stall = s_tvalid0 && !s_tready;
                prev_data  = s_tdata0;
                if (sof0) begin
                    obs_sof++;
                    sof_data = s_tdata0;
                    check1("sof_with_valid", s_tvalid0, 1'b1);
                end
                if (m_tvalid && !m_tready0) saw_ready_low = 1'b1;
                if (m_tvalid && m_tready0) model_beat(m_tdata, m_tuser, m_tlast);
                if (s_tvalid0 && s_tready) begin
                    got_q.push_back('{s_tdata0, s_tdata1, s_tuser0, s_tlast0});
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_extra: got word %h expected no word", s_tdata0);
                    end else begin
                        w = exp_q.pop_front();
                        check("sb_data_pad0", s_tdata0, w.d0);
                        check("sb_data_pad1", s_tdata1, w.d1);
                        check1("sb_tuser", s_tuser0, w.user);
                        check1("sb_tlast", s_tlast0, w.last);
                    end
                end
            end
        end
    end

    // Present one beat (called and returning at posedge+1) and hold until taken
    task automatic send_beat(input logic [31:0] d, input logic u, input logic l);
        int n;
        n        = 0;
        m_tdata  = d;
        m_tuser  = u;
        m_tlast  = l;
        m_tvalid = 1'b1;
        @(negedge clk);
        while (!m_tready0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check1("send_accept", m_tready0, 1'b1);
        @(posedge clk);
        #1;
        m_tvalid = 1'b0;
        m_tuser  = 1'b0;
        m_tlast  = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int c;
        c = 0;
        while (got_q.size() < n && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("word_count", got_q.size(), n);
    endtask

    initial begin
        vec_t        tbl[6];
        logic [31:0] px[8];
        logic [15:0] lo, hi;
        int          lat;
        int          sof_before;
        bit          rdone;

        tbl[0] = '{32'hFF000000, 32'h00FF0000, 32'h07E0001F, 32'h07E0001F};
        tbl[1] = '{32'h0000FF00, 32'h0000FF00, 32'hF800F800, 32'hF800F800};
        tbl[2] = '{32'h84000000, 32'hFE000000, 32'h001F0010, 32'h001F0011};
        tbl[3] = '{32'h12345678, 32'hABCDEF01, 32'hEE7551A2, 32'hF67559A2};
        tbl[4] = '{32'h07030300, 32'h00000000, 32'h00000000, 32'h00000021};
        tbl[5] = '{32'h0000FC00, 32'h00FD0000, 32'h07E0F800, 32'h07E0F800};

        rst      = 1'b1;
        m_tdata  = 32'h0;
        m_tvalid = 1'b0;
        m_tuser  = 1'b0;
        m_tlast  = 1'b0;
        s_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check1("rst_tvalid", s_tvalid0, 1'b0);
        check("rst_tdata", s_tdata0, 32'h0);
        check1("rst_tuser", s_tuser0, 1'b0);
        check1("rst_tlast", s_tlast0, 1'b0);
        check1("rst_sof", sof0, 1'b0);
        check1("rst_mready", m_tready0, 1'b1);

        // Table of two-pixel frames: data, sideband and latency
        for (int i = 0; i < 6; i++) begin
            got_q.delete();
            send_beat(tbl[i].p0, 1'b1, 1'b0);
            send_beat(tbl[i].p1, 1'b0, 1'b1);
            lat = 1;
            while (!s_tvalid0 && lat < 8) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("latency", lat, EXP_LAT);
            wait_words(1);
            if (got_q.size() > 0) begin
                check("tbl_data", got_q[0].d0, ROUND ? tbl[i].exp_r : tbl[i].exp_t);
                check1("tbl_tuser", got_q[0].user, 1'b1);
                check1("tbl_tlast", got_q[0].last, 1'b1);
            end
        end

        // Odd line of three blue pixels
        got_q.delete();
        send_beat(32'h0000FF00, 1'b0, 1'b0);
        send_beat(32'h0000FF00, 1'b0, 1'b0);
        send_beat(32'h0000FF00, 1'b0, 1'b1);
        wait_words(2);
        if (got_q.size() >= 2) begin
            check("odd_w0", got_q[0].d0, 32'hF800F800);
            check1("odd_w0_last", got_q[0].last, 1'b0);
            check("odd_w1_pad0", got_q[1].d0, 32'h0000F800);
            check("odd_w1_pad1", got_q[1].d1, 32'hF800F800);
            check1("odd_w1_last", got_q[1].last, 1'b1);
        end

        // Backpressure: eight pixels with a five-cycle downstream stall
        got_q.delete();
        saw_ready_low = 1'b0;
        for (int i = 0; i < 8; i++) px[i] = $urandom;
        fork
            begin
                for (int i = 0; i < 8; i++) send_beat(px[i], 1'b0, (i == 7));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                s_tready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                s_tready = 1'b1;
            end
        join
        wait_words(4);
        repeat (4) @(posedge clk);
        #1;
        check("bp_words", got_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) begin
                lo = conv(px[2*i]);
                hi = conv(px[2*i+1]);
                check("bp_data", got_q[i].d0, {hi, lo});
                check1("bp_last", got_q[i].last, (i == 3));
            end
        end
        check1("bp_ready_dropped", saw_ready_low, 1'b1);

        // Misaligned start of frame on the second pixel of a pair
        got_q.delete();
        sof_before = obs_sof;
        send_beat(32'h00000800, 1'b0, 1'b0);
        send_beat(32'h00FF0000, 1'b1, 1'b0);
        send_beat(32'hFF000000, 1'b0, 1'b1);
        wait_words(2);
        if (got_q.size() >= 2) begin
            check("sof_flush_pad0", got_q[0].d0, 32'h00000800);
            check("sof_flush_pad1", got_q[0].d1, 32'h08000800);
            check1("sof_flush_last", got_q[0].last, 1'b1);
            check1("sof_flush_user", got_q[0].user, 1'b0);
            check("sof_next", got_q[1].d0, 32'h001F07E0);
            check1("sof_next_user", got_q[1].user, 1'b1);
            check1("sof_next_last", got_q[1].last, 1'b1);
        end
        check("sof_pulses", obs_sof - sof_before, 1);
        check("sof_pulse_word", sof_data, 32'h00000800);

        // Reset while a word is stalled and a pixel is held
        s_tready = 1'b0;
        send_beat(32'h11223300, 1'b0, 1'b0);
        send_beat(32'h44556600, 1'b0, 1'b0);
        send_beat(32'h77889900, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check1("rst_mid_tvalid", s_tvalid0, 1'b0);
        check1("rst_mid_mready", m_tready0, 1'b1);
        s_tready = 1'b1;
        got_q.delete();
        send_beat(32'hFF000000, 1'b1, 1'b0);
        send_beat(32'h0000FF00, 1'b0, 1'b1);
        wait_words(1);
        repeat (4) @(posedge clk);
        #1;
        check("rst_mid_words", got_q.size(), 1);
        if (got_q.size() > 0) begin
            check("rst_mid_data", got_q[0].d0, 32'hF800001F);
            check1("rst_mid_user", got_q[0].user, 1'b1);
        end

        // Random traffic against the scoreboard
        rdone = 1'b0;
        fork
            begin
                for (int k = 0; k < 600; k++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send_beat($urandom, ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0));
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #1;
                    s_tready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        s_tready = 1'b1;
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        repeat (4) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
        check("sof_total", obs_sof, exp_sof);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
